// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, fetch FSM states and constants for the mips4 pipeline
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    typedef enum logic {FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: resolves redirect decision and target from execute-stage control
module next_pc_calc (
    input  logic        Branch,
    input  logic        NotEqualBranch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [31:0] ex_pc4,
    input  logic [15:0] ex_imm,
    input  logic [25:0] ex_target,
    output logic        take,
    output logic [31:0] target
);
    always_comb begin
        take   = Jump | (Branch & Zero) | (NotEqualBranch & ~Zero);
        target = Jump ? {ex_pc4[31:28], ex_target, 2'b00}
                      : ex_pc4 + {{14{ex_imm[15]}}, ex_imm, 2'b00};
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, req/ack instruction fetch and single-entry IF/ID register
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Branch,
    input  logic        NotEqualBranch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [31:0] ex_pc4,
    input  logic [15:0] ex_imm,
    input  logic [25:0] ex_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct
);
    fetch_state_t state, state_n;
    logic [31:0] pc, drain_addr, target;
    logic        pending, take, slot_free, xfer;

    next_pc_calc u_npc (
        .Branch(Branch),
        .NotEqualBranch(NotEqualBranch),
        .Jump(Jump),
        .Zero(Zero),
        .ex_pc4(ex_pc4),
        .ex_imm(ex_imm),
        .ex_target(ex_target),
        .take(take),
        .target(target)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // DRAIN keeps the abandoned request alive at its original address until memory acks it
    always_comb begin
        slot_free = ~id_valid | id_ready;
        imem_req  = (state == DRAIN) | slot_free | pending;
        imem_addr = (state == DRAIN) ? drain_addr : pc;
        xfer      = imem_req & imem_ack & (state == FETCH) & ~take;
        state_n   = (state == DRAIN && imem_ack) ? FETCH : state;
        if (take) state_n = (imem_req && !imem_ack) ? DRAIN : FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            pending    <= 1'b0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc4     <= 32'h0;
        end else begin
            pending    <= imem_req & ~imem_ack;
            drain_addr <= imem_addr;
            if (take) begin
                pc       <= target;
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end else if (xfer) begin
                pc       <= pc + 32'd4;
                id_pc4   <= pc + 32'd4;
                id_instr <= imem_rdata;
                id_valid <= 1'b1;
            end else if (id_ready) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

    assign Opcode = id_instr[31:26];
    assign Funct  = id_instr[5:0];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        Branch = 1'b0, NotEqualBranch = 1'b0, Jump = 1'b0, Zero = 1'b0;
    logic [31:0] ex_pc4 = 32'h0;
    logic [15:0] ex_imm = 16'h0;
    logic [25:0] ex_target = 26'h0;
    logic        id_ready = 1'b1, id_valid;
    logic [31:0] id_instr, id_pc4;
    logic [5:0]  Opcode, Funct;
    logic        drn = 1'b0;
    logic [63:0] q[$];
    logic [63:0] e;
    int n = 0, nf = 0;

    instr_fetch dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Branch(Branch), .NotEqualBranch(NotEqualBranch), .Jump(Jump), .Zero(Zero),
        .ex_pc4(ex_pc4), .ex_imm(ex_imm), .ex_target(ex_target),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
        .Opcode(Opcode), .Funct(Funct)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // memory returns its own address as data; a completed, non-redirected fetch is queued for the next edge
    task automatic cyc();
        logic tk;
        #1;
        imem_rdata = imem_addr;
        tk = Jump | (Branch & Zero) | (NotEqualBranch & ~Zero);
        if (imem_req && imem_ack && !tk && !drn && !reset)
            q.push_back({imem_rdata, imem_addr + 32'd4});
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_valid", {31'b0, id_valid}, 32'd1);
            chk("sb_instr", id_instr, e[63:32]);
            chk("sb_pc4", id_pc4, e[31:0]);
        end
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_opcode", {26'b0, Opcode}, 32'd0);
        chk("rst_funct", {26'b0, Funct}, 32'd0);
        reset = 1'b0;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        // stream
        imem_ack = 1'b1;
        id_ready = 1'b1;
        cyc(); cyc(); cyc();
        // stall
        imem_ack = 1'b0;
        id_ready = 1'b0;
        #1;
        chk("stall_req0", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_valid", {31'b0, id_valid}, 32'd1);
            chk("stall_instr", id_instr, 32'h8);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        id_ready = 1'b1;
        #1;
        chk("release_req", {31'b0, imem_req}, 32'd1);
        chk("release_addr", imem_addr, 32'hC);
        cyc();
        chk("consumed_valid", {31'b0, id_valid}, 32'd0);
        chk("pending_addr", imem_addr, 32'hC);
        imem_ack = 1'b1;
        cyc();
        // BEQ taken with same-cycle ack discarded
        Branch = 1'b1; Zero = 1'b1; ex_pc4 = 32'h100; ex_imm = 16'hFFFF;
        cyc();
        chk("beq_valid", {31'b0, id_valid}, 32'd0);
        chk("beq_instr", id_instr, 32'h0);
        chk("beq_addr", imem_addr, 32'hFC);
        Branch = 1'b0; NotEqualBranch = 1'b1;
        cyc();
        chk("bne_addr", imem_addr, 32'h100);
        NotEqualBranch = 1'b0;
        // jump
        Jump = 1'b1; ex_pc4 = 32'h1000_0040; ex_target = 26'h40;
        cyc();
        chk("j_valid", {31'b0, id_valid}, 32'd0);
        chk("j_addr", imem_addr, 32'h1000_0100);
        Jump = 1'b0;
        cyc();
        chk("j_opcode", {26'b0, Opcode}, 32'd4);
        chk("j_funct", {26'b0, Funct}, 32'd0);
        // redirect while a request waits
        imem_ack = 1'b0;
        cyc();
        chk("wait_addr", imem_addr, 32'h1000_0104);
        Jump = 1'b1; ex_pc4 = 32'h40; ex_target = 26'h80;
        cyc();
        Jump = 1'b0;
        drn = 1'b1;
        chk("drain_req", {31'b0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h1000_0104);
        cyc();
        chk("drain_addr2", imem_addr, 32'h1000_0104);
        imem_ack = 1'b1;
        cyc();
        drn = 1'b0;
        chk("drain_valid", {31'b0, id_valid}, 32'd0);
        chk("drain_instr", id_instr, 32'h0);
        chk("redir_req", {31'b0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h200);
        // reset with a request outstanding
        cyc();
        imem_ack = 1'b0;
        cyc();
        chk("pre_rst_addr", imem_addr, 32'h204);
        reset = 1'b1;
        cyc();
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_req", {31'b0, imem_req}, 32'd1);
        chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
        chk("mid_rst_opcode", {26'b0, Opcode}, 32'd0);
        chk("mid_rst_funct", {26'b0, Funct}, 32'd0);
        reset = 1'b0;
        imem_ack = 1'b1;
        cyc();
        chk("sb_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the mips4 pipeline. Holds the PC and issues word reads to instruction memory over a req/ack handshake. Latches each returned word into a single-entry IF/ID register whose Opcode/Funct fields drive Control directly. Consumes the Branch/NotEqualBranch/Jump outcome from downstream and redirects the PC, flushing the wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word address; held stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  transfer completes in any cycle with imem_req=1 and imem_ack=1
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- Branch, NotEqualBranch, Jump  in  1 each  resolved control for the instruction in execute
- Zero  in  1  ALU zero flag for that instruction
- ex_pc4  in  32  PC+4 of the instruction in execute
- ex_imm  in  16  its immediate field
- ex_target  in  26  its jump target field
- id_ready  in  1  decode accepts id_* this cycle
- id_valid  out  1  IF/ID register holds a valid instruction
- id_instr  out  32  latched instruction; 32'h0 when invalid
- id_pc4  out  32  PC+4 of id_instr
- Opcode  out  6  id_instr[31:26], to Control
- Funct  out  6  id_instr[5:0], to Control

## Operation
- take = Jump | (Branch & Zero) | (NotEqualBranch & ~Zero).
- Target: Jump -> {ex_pc4[31:28], ex_target, 2'b00}. Otherwise ex_pc4 + {{14{ex_imm[15]}}, ex_imm, 2'b00}, 32-bit wrap.
- slot_free = ~id_valid | id_ready.
- States: FETCH, DRAIN.
- FETCH behaviour:
  - imem_req = slot_free | pending, where pending = req asserted last cycle without ack.
  - imem_addr = pc.
  - On ack without take: id_instr <= imem_rdata, id_pc4 <= pc+4, id_valid <= 1, pc <= pc+4.
  - If id_ready with no ack: id_valid <= 0, id_instr <= 0.
- DRAIN behaviour:
  - imem_req=1 at the old address until ack.
  - Returned data is discarded.
  - On ack, go to FETCH.
- take, any state:
  - pc <= target; id_valid <= 0, id_instr <= 0. Flush beats id_ready.
  - If req=1 and ack=0 this cycle, go to DRAIN.
  - Otherwise go to (or stay in) FETCH; same-cycle ack data is discarded.
  - take in DRAIN updates pc again.
- Jump has priority over branch when both are asserted.
- Reset values: pc=RESET_PC, state=FETCH, id_valid=0, id_instr=0, id_pc4=0, pending=0, so Opcode=0 and Funct=0. Any outstanding memory transfer is abandoned.

## Timing
- First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- Fetch latency: ack in cycle N -> id_valid=1 in N+1.
- Throughput: 1 instruction/cycle with ack and id_ready held high.
- Backpressure: id_valid=1 and id_ready=0 -> no new req issued; an already-pending req stays asserted with a stable address.
- Redirect: take in cycle N -> imem_addr=target at N+1 (FETCH). In DRAIN, imem_addr=target in the cycle after the draining ack.
- Simultaneous ack and id_ready: the slot is consumed and refilled in the same edge, so id_valid stays 1.

## Structure
- Shared package mips_pkg:
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_LW=35, OP_SW=43
  - fetch state enum
  - NOP_INSTR=32'h0
- One sub-module, next_pc_calc: combinational take/target from the Branch, NotEqualBranch, Jump, Zero and ex_* inputs.

## Test plan
- Stream: ack every cycle, rdata=addr, id_ready=1 -> id_instr 0x0,0x4,0x8 with id_pc4 0x4,0x8,0xC on consecutive cycles.
- Stall: id_ready=0 for 3 cycles with id_valid=1 -> id_instr held, imem_req=0; release -> next req at pc+4 in the following cycle.
- BEQ taken: Branch=1, Zero=1, ex_pc4=0x100, ex_imm=0xFFFF -> id_valid=0 and imem_addr=0xFC next cycle. Same inputs with NotEqualBranch=1 instead of Branch -> no redirect.
- Jump: ex_pc4=0x1000_0040, ex_target=0x40 -> imem_addr=0x1000_0100 next cycle.
- Redirect during a wait: req pending, take while ack is delayed 2 cycles -> DRAIN, old address held, returned word not latched, then req at target.
- Reset mid-transfer: reset while req pending -> next cycle imem_addr=RESET_PC, id_valid=0, Opcode=0, Funct=0.
